i2c_master_tx: RTL
==================

# i2c_master_tx

Synchronous I2C write-only controller. It generates START, repeated-START and STOP conditions, shifts command bytes out MSB first, and samples the target's ACK bit. It sits between a command-issuing core (handshake interface) and the open-drain SCL/SDA pads. Output 1 releases a line and output 0 pulls it low.

## Interface
- DIV, default 4: system clocks per SCL quarter-period (≥1). One SCL bit = 4·DIV clocks.
- clk  in  1  system clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_start  in  1  precede byte with repeated START; only honoured in HOLD
- cmd_stop  in  1  issue STOP after this byte's ACK
- cmd_data  in  8  byte to transmit
- sda_in  in  1  sampled SDA line, pre-synchronised
- scl_out  out  1  SCL drive (1 = release)
- sda_out  out  1  SDA drive (1 = release)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of ACK bit
- nack  out  1  ACK result, valid while done=1 and held until next done

## Operation
- States: IDLE, START, DATA, ACK, HOLD, STOP. A quarter counter (0..DIV-1) and a quarter index q0..q3 pace every state except IDLE and HOLD.
- IDLE: scl=1, sda=1, cmd_ready=1. On acceptance, latch cmd_data/cmd_stop, go to START. The START is unconditional and cmd_start is ignored.
- START quarters (scl,sda):
  - q0: (prev scl,1), where prev scl is 1 from IDLE and 0 from HOLD
  - q1: (1,1)
  - q2: (1,0)
  - q3: (1,0)
  - Then DATA, bit 7.
- DATA, per bit: q0 scl=0 with sda set to the current bit; q1 scl=0; q2 and q3 scl=1. After q3 of bit 0, go to ACK. Bits are sent 7 down to 0.
- ACK: sda=1 (released), SCL pattern as DATA. Sample sda_in on the last clock of q2; sampled 1 means nack=1. On the last clock of q3, pulse done.
  - nack=1: go to STOP regardless of cmd_stop.
  - nack=0 and cmd_stop: go to STOP.
  - Otherwise: go to HOLD.
- HOLD: scl=0, sda=1, cmd_ready=1, bus owned indefinitely. On acceptance:
  - cmd_start=1: go to START (repeated start).
  - cmd_start=0: go directly to DATA bit 7.
- STOP quarters (scl,sda):
  - q0: (0,0)
  - q1: (1,0)
  - q2: (1,0)
  - q3: (1,1)
  - Then IDLE.
- cmd_ready=0 in START/DATA/ACK/STOP. cmd_valid in those states is ignored, not queued.
- The byte shifts in an 8-bit register. The bit index is a 3-bit down-counter and does not wrap: ACK follows index 0.

## Timing
- All outputs are registered and change only on clk rising edge.
- Reset values:
  - state IDLE
  - scl_out=1, sda_out=1
  - cmd_ready=1
  - busy=0, done=0, nack=0
  - counters 0
- Acceptance in cycle 0 means the first START clock is cycle 1, with busy=1 from cycle 1.
- From IDLE: done in cycle 40·DIV, which is 4·DIV START + 32·DIV DATA + 4·DIV ACK clocks.
- With cmd_stop: IDLE returns at cycle 44·DIV+1 (busy=0 and cmd_ready=1 there).
- From HOLD without start: done at 36·DIV after acceptance.
- SDA changes only while SCL=0, except the START/STOP edges.
- Reset asserted mid-operation: the next cycle shows IDLE values and lines released. No STOP is generated and done is not pulsed.
- Reset and cmd_valid in the same cycle: reset wins and no command is latched.

## Test plan
- DIV=2, accept 0xA5 with cmd_stop=1, bench pulls sda_in=0 in ACK:
  - DATA sda sequence 1,0,1,0,0,1,0,1
  - done at cycle 80 with nack=0
  - STOP completes and busy falls at cycle 89
- Same byte with sda_in=1 in ACK and cmd_stop=0: done with nack=1, STOP forced, IDLE reached, not HOLD.
- 0x3C with cmd_stop=0 (HOLD), then 0x81 with cmd_start=0 and cmd_stop=1:
  - HOLD holds scl=0 for 10 idle cycles
  - second done at 72 cycles after second acceptance
  - no START between the two bytes
- 0x50 with stop=0, then 0x51 with cmd_start=1:
  - repeated START: from scl=0, sda rises first, then scl rises, then sda falls while scl=1
- Assert rst during DATA bit 4: the next cycle shows scl_out=1, sda_out=1, busy=0, done=0; a new command then runs normally.
- Hold cmd_valid high with different cmd_data through a transfer: only bytes accepted in IDLE/HOLD are sent, and cmd_ready=0 at every cycle in between.

Source files
------------

// File: rtl/i2c_master_tx.sv
// Write-only I2C controller: START/repeated-START/STOP generation, MSB-first byte
// shifting and ACK sampling, paced in SCL quarter-periods of DIV system clocks.
module i2c_master_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic [7:0] cmd_data,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_ACK   = 3'd3,
    S_HOLD  = 3'd4,
    S_STOP  = 3'd5
  } state_e;

  state_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          stop_q, stop_d;
  logic          prev_scl_q, prev_scl_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          nack_q, nack_d;

  logic last_clk_c;
  logic end_phase_c;
  logic accept_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= S_IDLE;
      cnt_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      stop_q     <= 1'b0;
      prev_scl_q <= 1'b1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      stop_q     <= stop_d;
      prev_scl_q <= prev_scl_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
    end
  end

  // Next state, then outputs derived from the next state so the registered
  // line levels always describe the state being occupied in that cycle.
  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    stop_d     = stop_q;
    prev_scl_d = prev_scl_q;
    nack_d     = nack_q;
    scl_d      = 1'b1;
    sda_d      = 1'b1;
    ready_d    = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    last_clk_c  = (cnt_q == CNT_LAST);
    end_phase_c = last_clk_c && (qtr_q == 2'd3);
    accept_c    = cmd_valid && ready_q;

    if (st_q == S_START || st_q == S_DATA || st_q == S_ACK || st_q == S_STOP) begin
      cnt_d = last_clk_c ? '0 : CW'(cnt_q + 1'b1);
      if (last_clk_c) qtr_d = 2'(qtr_q + 2'd1);
    end

    case (st_q)
      S_IDLE: begin
        if (accept_c) begin
          sh_d       = cmd_data;
          stop_d     = cmd_stop;
          prev_scl_d = 1'b1;
          cnt_d      = '0;
          qtr_d      = '0;
          st_d       = S_START;
        end
      end
      S_HOLD: begin
        if (accept_c) begin
          sh_d       = cmd_data;
          stop_d     = cmd_stop;
          prev_scl_d = 1'b0;
          cnt_d      = '0;
          qtr_d      = '0;
          bit_d      = 3'd7;
          st_d       = cmd_start ? S_START : S_DATA;
        end
      end
      S_START: begin
        if (end_phase_c) begin
          bit_d = 3'd7;
          st_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (end_phase_c) begin
          if (bit_q == 3'd0) st_d = S_ACK;
          else bit_d = 3'(bit_q - 3'd1);
        end
      end
      S_ACK: begin
        if (last_clk_c && qtr_q == 2'd2) nack_d = sda_in;
        if (end_phase_c) st_d = (nack_q || stop_q) ? S_STOP : S_HOLD;
      end
      S_STOP: begin
        if (end_phase_c) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase

    case (st_d)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_HOLD: begin
        scl_d   = 1'b0;
        ready_d = 1'b1;
      end
      S_START: begin
        scl_d = (qtr_d == 2'd0) ? prev_scl_d : 1'b1;
        sda_d = (qtr_d < 2'd2);
      end
      S_DATA: begin
        scl_d = qtr_d[1];
        sda_d = sh_d[bit_d];
      end
      S_ACK: begin
        scl_d  = qtr_d[1];
        done_d = (qtr_d == 2'd3) && (cnt_d == CNT_LAST);
      end
      S_STOP: begin
        scl_d = (qtr_d != 2'd0);
        sda_d = (qtr_d == 2'd3);
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign cmd_ready = ready_q;
  assign scl_out   = scl_q;
  assign sda_out   = sda_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign nack      = nack_q;

endmodule
